// File: rtl/uart_defs.sv
// Shared UART definitions: frame state encoding, byte type and bit-period derivation.
// Used by both uart_tx and uart_rx.
package uart_defs;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    START = 2'd1,
    DATA  = 2'd2,
    STOP  = 2'd3
  } uart_state_t;

  typedef logic [7:0] uart_byte_t;

  localparam int unsigned DATA_BITS = 8;

  // Clock cycles per line bit (integer division).
  function automatic int unsigned cyc_count(input int unsigned sys_clk, input int unsigned baud);
    return sys_clk / baud;
  endfunction

endpackage

// File: rtl/uart_tx_if.sv
// Byte handshake between a producer and the UART transmitter.
interface uart_tx_if;
  import uart_defs::*;

  logic       din_valid;
  uart_byte_t din;
  logic       din_ready;

  modport master (output din_valid, output din, input din_ready);
  modport slave  (input din_valid, input din, output din_ready);

endinterface

// File: rtl/uart_rx.sv
// 8N1 UART receiver: synchronises din, samples each bit mid-period, pulses valid on a good stop bit.
module uart_rx
  import uart_defs::*;
#(
  parameter int unsigned SYSTEM_CLOCK = 32000000,
  parameter int unsigned BAUD_RATE    = 9600
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       din,
  output logic       valid,
  output uart_byte_t data_rx
);

  localparam int unsigned CYC_COUNT = cyc_count(SYSTEM_CLOCK, BAUD_RATE);
  localparam int unsigned CNT_W     = $clog2(CYC_COUNT) + 1;
  localparam int unsigned HALF      = (CYC_COUNT / 2 > 0) ? CYC_COUNT / 2 : 1;
  localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(CYC_COUNT - 1);
  localparam logic [CNT_W-1:0] HALF_CYC = CNT_W'(HALF - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  uart_byte_t       shreg_q, shreg_d;
  uart_byte_t       data_d;
  logic             valid_d;
  logic             din_s1, din_s2;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      din_s1  <= 1'b1;
      din_s2  <= 1'b1;
      state_q <= IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shreg_q <= '0;
      valid   <= 1'b0;
      data_rx <= '0;
    end else begin
      din_s1  <= din;
      din_s2  <= din_s1;
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      shreg_q <= shreg_d;
      valid   <= valid_d;
      data_rx <= data_d;
    end
  end

  // START waits half a bit to land every later sample mid-bit.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    data_d  = data_rx;
    valid_d = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!din_s2) state_d = START;
      end
      START: begin
        if (cnt_q == HALF_CYC) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = din_s2 ? IDLE : DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        if (cnt_q == LAST_CYC) begin
          cnt_d   = '0;
          shreg_d = {din_s2, shreg_q[7:1]};
          if (bit_q == LAST_BIT) state_d = STOP;
          else                   bit_d   = bit_q + 3'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        if (cnt_q == LAST_CYC) begin
          cnt_d   = '0;
          state_d = IDLE;
          if (din_s2) begin
            valid_d = 1'b1;
            data_d  = shreg_q;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: rtl/uart_tx_fifo.sv
// Byte buffer for uart_tx; power-of-two depth, pointers wrap naturally.
module uart_tx_fifo
  import uart_defs::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   wr_en,
  input  uart_byte_t             wr_data,
  input  logic                   pop,
  output uart_byte_t             dout,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned LVL_W = PTR_W + 1;

  uart_byte_t       mem [DEPTH];
  logic [PTR_W-1:0] wr_ptr;
  logic [PTR_W-1:0] rd_ptr;
  logic             push;
  logic             do_pop;

  assign full   = (count == LVL_W'(DEPTH));
  assign empty  = (count == '0);
  assign push   = wr_en & ~full;
  assign do_pop = pop & ~empty;
  assign dout   = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= wr_data;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push)   wr_ptr <= wr_ptr + PTR_W'(1);
      if (do_pop) rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, do_pop})
        2'b10:   count <= count + LVL_W'(1);
        2'b01:   count <= count - LVL_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/uart_tx.sv
// 8N1 UART transmitter with a small byte buffer in front of the frame shifter.
module uart_tx
  import uart_defs::*;
#(
  parameter int unsigned SYSTEM_CLOCK = 32000000,
  parameter int unsigned BAUD_RATE    = 9600,
  parameter int unsigned FIFO_DEPTH   = 4
) (
  input  logic      clk,
  input  logic      rst,
  uart_tx_if.slave  bus,
  output logic      tx,
  output logic      busy
);

  localparam int unsigned CYC_COUNT = cyc_count(SYSTEM_CLOCK, BAUD_RATE);
  localparam int unsigned CNT_W     = $clog2(CYC_COUNT) + 1;
  localparam int unsigned LVL_W     = $clog2(FIFO_DEPTH) + 1;
  localparam logic [CNT_W-1:0] LAST_CYC = CNT_W'(CYC_COUNT - 1);
  localparam logic [2:0]       LAST_BIT = 3'(DATA_BITS - 1);

  uart_state_t      state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [2:0]       bit_q, bit_d;
  uart_byte_t       shreg_q, shreg_d;
  logic             tx_d;
  logic             ready_en_q;
  logic             pop;
  logic             wr_en;
  uart_byte_t       fifo_dout;
  logic             fifo_full;
  logic             fifo_empty;
  logic [LVL_W-1:0] fifo_count;

  // ready_en_q keeps din_ready low through reset and lifts it on the first edge after.
  assign bus.din_ready = ready_en_q & ~fifo_full;
  assign wr_en         = bus.din_valid & bus.din_ready;
  assign busy          = (state_q != IDLE) || (fifo_count != '0);

  uart_tx_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .wr_en   (wr_en),
    .wr_data (bus.din),
    .pop     (pop),
    .dout    (fifo_dout),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= IDLE;
      cnt_q      <= '0;
      bit_q      <= '0;
      shreg_q    <= '0;
      tx         <= 1'b1;
      ready_en_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      bit_q      <= bit_d;
      shreg_q    <= shreg_d;
      tx         <= tx_d;
      ready_en_q <= 1'b1;
    end
  end

  // tx_d reflects the current state, so the line lags the state by one cycle uniformly.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    shreg_d = shreg_q;
    tx_d    = 1'b1;
    pop     = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (!fifo_empty) begin
          pop     = 1'b1;
          shreg_d = fifo_dout;
          state_d = START;
        end
      end
      START: begin
        tx_d = 1'b0;
        if (cnt_q == LAST_CYC) begin
          cnt_d   = '0;
          bit_d   = '0;
          state_d = DATA;
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      DATA: begin
        tx_d = shreg_q[0];
        if (cnt_q == LAST_CYC) begin
          cnt_d   = '0;
          shreg_d = {1'b0, shreg_q[7:1]};
          if (bit_q == LAST_BIT) state_d = STOP;
          else                   bit_d   = bit_q + 3'(1);
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      STOP: begin
        tx_d = 1'b1;
        if (cnt_q == LAST_CYC) begin
          cnt_d = '0;
          if (!fifo_empty) begin
            pop     = 1'b1;
            shreg_d = fifo_dout;
            state_d = START;
          end else begin
            state_d = IDLE;
          end
        end else begin
          cnt_d = cnt_q + CNT_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

endmodule

// File: tb/tb_uart_tx.sv
// Directed bench for uart_tx at CYC_COUNT=16, with uart_rx on the line for loopback.
module tb_uart_tx;

  logic       clk = 1'b0;
  logic       rst;
  logic       tx;
  logic       busy;
  logic       rx_valid;
  logic [7:0] rx_data;
  logic [7:0] rx_q [$];
  int         checks = 0;
  int         errors = 0;

  uart_tx_if bus ();

  uart_tx #(.SYSTEM_CLOCK(160), .BAUD_RATE(10), .FIFO_DEPTH(4)) dut (
    .clk  (clk),
    .rst  (rst),
    .bus  (bus),
    .tx   (tx),
    .busy (busy)
  );

  uart_rx #(.SYSTEM_CLOCK(160), .BAUD_RATE(10)) u_rx (
    .clk     (clk),
    .rst     (rst),
    .din     (tx),
    .valid   (rx_valid),
    .data_rx (rx_data)
  );

  always #5 clk = ~clk;

  always @(posedge clk) begin
    if (rx_valid) rx_q.push_back(rx_data);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_rx(input logic [7:0] exp, input string tag);
    int n;
    logic [7:0] got;
    n = 0;
    while (rx_q.size() == 0 && n < 400) begin
      tick(1);
      n++;
    end
    chk({tag, "_seen"}, 32'(rx_q.size() != 0), 32'(1));
    if (rx_q.size() != 0) begin
      got = rx_q.pop_front();
      chk(tag, 32'(got), 32'(exp));
    end
  endtask

  // Called just after the accepting edge E0; walks the frame edge by edge to E162.
  task automatic check_frame(input logic [7:0] b, input string tag);
    logic [9:0] frame;
    frame = {1'b1, b, 1'b0};
    tick(1);
    chk({tag, "_tx_e1"}, 32'(tx), 32'(1));
    tick(1);
    for (int k = 0; k < 10; k++) begin
      chk({tag, "_bit_first"}, 32'(tx), 32'(frame[k]));
      tick(14);
      if (k == 9) chk({tag, "_busy_e160"}, 32'(busy), 32'(1));
      tick(1);
      chk({tag, "_bit_last"}, 32'(tx), 32'(frame[k]));
      chk({tag, "_busy"}, 32'(busy), 32'(k != 9));
      tick(1);
    end
  endtask

  initial begin
    int         j;
    logic [9:0] fr;
    logic       ex;

    rst           = 1'b0;
    bus.din_valid = 1'b0;
    bus.din       = 8'h00;

    // Asynchronous reset before any clock edge.
    #1 rst = 1'b1;
    #1;
    chk("rst_tx", 32'(tx), 32'(1));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_ready", 32'(bus.din_ready), 32'(0));
    tick(3);
    chk("rst_ready_held", 32'(bus.din_ready), 32'(0));
    #2 rst = 1'b0;
    #1;
    chk("ready_before_edge", 32'(bus.din_ready), 32'(0));
    tick(1);
    chk("ready_after_rst", 32'(bus.din_ready), 32'(1));
    tick(2);

    // Single byte 0xA5.
    rx_q.delete();
    bus.din_valid = 1'b1;
    bus.din       = 8'hA5;
    tick(1);
    bus.din_valid = 1'b0;
    chk("single_busy_e0", 32'(busy), 32'(1));
    check_frame(8'hA5, "single");
    expect_rx(8'hA5, "single_rx");
    tick(4);

    // Burst of 8 writes: five accepted, five frames back to back.
    rx_q.delete();
    for (int i = 0; i < 8; i++) begin
      bus.din_valid = 1'b1;
      bus.din       = 8'(i + 1);
      chk("burst_ready", 32'(bus.din_ready), 32'(i < 5));
      tick(1);
    end
    bus.din_valid = 1'b0;
    for (int k = 8; k <= 803; k++) begin
      tick(1);
      j = k - 2;
      if (j >= 800) ex = 1'b1;
      else begin
        fr = {1'b1, 8'(j / 160 + 1), 1'b0};
        ex = fr[(j % 160) / 16];
      end
      chk("burst_tx", 32'(tx), 32'(ex));
      chk("burst_busy", 32'(busy), 32'(k <= 800));
    end
    for (int i = 0; i < 5; i++) expect_rx(8'(i + 1), "burst_rx");
    tick(20);
    chk("burst_rx_extra", 32'(rx_q.size()), 32'(0));

    // Full boundary: write held across the pop that frees a slot.
    rx_q.delete();
    for (int i = 0; i < 5; i++) begin
      bus.din_valid = 1'b1;
      bus.din       = 8'(8'h11 + i);
      chk("fill_ready", 32'(bus.din_ready), 32'(1));
      tick(1);
    end
    bus.din = 8'hEE;
    chk("full_ready", 32'(bus.din_ready), 32'(0));
    tick(156);
    chk("full_pop_cycle_ready", 32'(bus.din_ready), 32'(0));
    tick(1);
    chk("after_pop_ready", 32'(bus.din_ready), 32'(1));
    bus.din = 8'h77;
    tick(1);
    bus.din_valid = 1'b0;
    chk("full_again_ready", 32'(bus.din_ready), 32'(0));
    for (int i = 0; i < 5; i++) expect_rx(8'(8'h11 + i), "full_rx");
    expect_rx(8'h77, "full_rx_late");
    tick(20);
    chk("full_rx_extra", 32'(rx_q.size()), 32'(0));
    chk("full_idle_busy", 32'(busy), 32'(0));

    // Reset during DATA bit 3 with a second byte buffered.
    rx_q.delete();
    bus.din_valid = 1'b1;
    bus.din       = 8'h96;
    tick(1);
    bus.din = 8'hC3;
    tick(1);
    bus.din_valid = 1'b0;
    tick(69);
    chk("pre_rst_tx", 32'(tx), 32'(0));
    chk("pre_rst_busy", 32'(busy), 32'(1));
    #3 rst = 1'b1;
    #1;
    chk("mid_rst_tx", 32'(tx), 32'(1));
    chk("mid_rst_busy", 32'(busy), 32'(0));
    chk("mid_rst_ready", 32'(bus.din_ready), 32'(0));
    tick(2);
    #2 rst = 1'b0;
    tick(1);
    chk("post_rst_ready", 32'(bus.din_ready), 32'(1));
    chk("post_rst_busy", 32'(busy), 32'(0));
    rx_q.delete();
    bus.din_valid = 1'b1;
    bus.din       = 8'h3C;
    tick(1);
    bus.din_valid = 1'b0;
    check_frame(8'h3C, "after_rst");
    expect_rx(8'h3C, "after_rst_rx");
    tick(200);
    chk("discarded_rx", 32'(rx_q.size()), 32'(0));
    chk("discarded_busy", 32'(busy), 32'(0));

    // Loopback through uart_rx.
    rx_q.delete();
    bus.din_valid = 1'b1;
    bus.din       = 8'h00;
    tick(1);
    bus.din = 8'hFF;
    tick(1);
    bus.din = 8'h5A;
    tick(1);
    bus.din_valid = 1'b0;
    expect_rx(8'h00, "loop_00");
    expect_rx(8'hFF, "loop_ff");
    expect_rx(8'h5A, "loop_5a");
    tick(40);
    chk("loop_idle_busy", 32'(busy), 32'(0));
    chk("loop_idle_tx", 32'(tx), 32'(1));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
